// File: rtl/ad7689_conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ad7689_conv_sequencer
// Description : Channel-scan sequencer for the AD7689 SAR ADC. Drives CNV, SCK
//               and DIN, shifts in SDO, and tags results through the two-frame
//               CFG pipeline of the converter.
// Revision    : 1.0 - initial release
// ============================================================================
module ad7689_conv_sequencer #(
    parameter int         CLK_DIV = 2,
    parameter int         T_CONV  = 230,
    parameter int         T_GAP   = 4,
    parameter logic [2:0] REF_SEL = 3'b001
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        enable,
    input  logic        continuous,
    input  logic        start,
    input  logic [7:0]  ch_mask,
    output logic        adc_cnv,
    output logic        adc_sck,
    output logic        adc_din,
    input  logic        adc_sdo,
    output logic [15:0] result_data,
    output logic [2:0]  result_ch,
    output logic        result_valid,
    output logic        scan_done,
    output logic        busy
);

    localparam logic [15:0] c_CONV_LAST = 16'(T_CONV - 1);
    localparam logic [15:0] c_HALF_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] c_GAP_LAST  = 16'(T_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CONV  = 3'd1,
        S_SETUP = 3'd2,
        S_XFER  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_cnt;
    logic [3:0]  r_bit;
    logic        r_cnv;
    logic        r_sck;
    logic        r_din;
    logic [15:0] r_tx;
    logic [15:0] r_rx;
    logic [7:0]  r_mask;
    logic [2:0]  r_ptr;
    logic        r_cur_valid;
    logic        r_cont;
    logic        r_stop;
    logic [1:0]  r_flush;
    logic        r_tag0_v;
    logic        r_tag1_v;
    logic [2:0]  r_tag0_ch;
    logic [2:0]  r_tag1_ch;
    logic        r_last_sample;
    logic [15:0] r_result_data;
    logic [2:0]  r_result_ch;
    logic        r_result_valid;
    logic        r_scan_done;

    logic        w_start_ok;
    logic        w_conv_end;
    logic        w_half_end;
    logic        w_xfer_end;
    logic        w_gap_end;
    logic        w_stop;
    logic        w_has_hi;
    logic [2:0]  w_ptr_hi;
    logic [13:0] w_cfg;

    function automatic logic [2:0] f_lowest(input logic [7:0] m);
        logic [2:0] v;
        v = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) v = 3'(i);
        end
        return v;
    endfunction

    assign w_cfg      = {1'b1, 3'b111, r_ptr, 1'b1, REF_SEL, 2'b00, 1'b1};
    assign w_start_ok = (r_state == S_IDLE) && start && enable && (ch_mask != 8'd0);
    assign w_conv_end = (r_state == S_CONV) && (r_cnt == c_CONV_LAST);
    assign w_half_end = (r_state == S_XFER) && (r_cnt == c_HALF_LAST);
    assign w_xfer_end = w_half_end && r_sck && (r_bit == 4'd15);
    assign w_gap_end  = (r_state == S_GAP) && (r_cnt == c_GAP_LAST);
    assign w_stop     = r_stop || !enable;

    // Next enabled channel strictly above the current pointer
    always_comb begin
        w_has_hi = 1'b0;
        w_ptr_hi = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_mask[i] && (3'(i) > r_ptr)) begin
                w_has_hi = 1'b1;
                w_ptr_hi = 3'(i);
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_CONV;
            S_CONV:  if (w_conv_end) w_state_nxt = S_SETUP;
            S_SETUP: w_state_nxt = S_XFER;
            S_XFER:  if (w_xfer_end) w_state_nxt = S_GAP;
            S_GAP: begin
                if (w_gap_end) w_state_nxt = (w_stop || r_flush == 2'd3) ? S_IDLE : S_CONV;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_cnt          <= '0;
            r_bit          <= '0;
            r_cnv          <= 1'b0;
            r_sck          <= 1'b0;
            r_din          <= 1'b0;
            r_tx           <= '0;
            r_rx           <= '0;
            r_mask         <= '0;
            r_ptr          <= '0;
            r_cur_valid    <= 1'b0;
            r_cont         <= 1'b0;
            r_stop         <= 1'b0;
            r_flush        <= '0;
            r_tag0_v       <= 1'b0;
            r_tag1_v       <= 1'b0;
            r_tag0_ch      <= '0;
            r_tag1_ch      <= '0;
            r_last_sample  <= 1'b0;
            r_result_data  <= '0;
            r_result_ch    <= '0;
            r_result_valid <= 1'b0;
            r_scan_done    <= 1'b0;
        end else begin
            r_last_sample  <= 1'b0;
            r_result_valid <= 1'b0;
            r_scan_done    <= 1'b0;

            if (r_state != S_IDLE && !enable) r_stop <= 1'b1;

            // Oldest tag describes the conversion whose bits just finished shifting in
            if (r_last_sample && r_tag1_v) begin
                r_result_valid <= 1'b1;
                r_result_data  <= r_rx;
                r_result_ch    <= r_tag1_ch;
                r_scan_done    <= !r_cont && (r_flush == 2'd2) && !w_stop;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_start_ok) begin
                        r_mask      <= ch_mask;
                        r_ptr       <= f_lowest(ch_mask);
                        r_cur_valid <= 1'b1;
                        r_cont      <= continuous;
                        r_stop      <= 1'b0;
                        r_flush     <= '0;
                        r_tag0_v    <= 1'b0;
                        r_tag1_v    <= 1'b0;
                        r_cnv       <= 1'b1;
                    end
                end
                S_CONV: begin
                    if (w_conv_end) begin
                        r_cnt <= '0;
                        r_cnv <= 1'b0;
                        r_din <= w_cfg[13];
                        r_tx  <= {w_cfg[12:0], 3'b000};
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_SETUP: begin
                    r_cnt <= '0;
                    r_bit <= '0;
                end
                S_XFER: begin
                    if (w_half_end) begin
                        r_cnt <= '0;
                        if (!r_sck) begin
                            r_sck         <= 1'b1;
                            r_rx          <= {r_rx[14:0], adc_sdo};
                            r_last_sample <= (r_bit == 4'd15);
                        end else begin
                            r_sck <= 1'b0;
                            r_din <= r_tx[15];
                            r_tx  <= {r_tx[14:0], 1'b0};
                            r_bit <= r_bit + 4'd1;
                            if (r_bit == 4'd15) begin
                                r_tag1_v  <= r_tag0_v;
                                r_tag1_ch <= r_tag0_ch;
                                r_tag0_v  <= r_cur_valid;
                                r_tag0_ch <= r_ptr;
                                if (r_flush != 2'd0) begin
                                    if (r_flush != 2'd3) r_flush <= r_flush + 2'd1;
                                end else if (w_has_hi) begin
                                    r_ptr <= w_ptr_hi;
                                end else if (r_cont) begin
                                    if (ch_mask != 8'd0) begin
                                        r_mask <= ch_mask;
                                        r_ptr  <= f_lowest(ch_mask);
                                    end else begin
                                        r_ptr  <= f_lowest(r_mask);
                                    end
                                end else begin
                                    // Two flush frames push the last tags out of the pipeline
                                    r_flush     <= 2'd1;
                                    r_cur_valid <= 1'b0;
                                    r_ptr       <= f_lowest(r_mask);
                                end
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_cnt <= '0;
                        if (w_stop || r_flush == 2'd3) begin
                            r_tag0_v    <= 1'b0;
                            r_tag1_v    <= 1'b0;
                            r_cur_valid <= 1'b0;
                            r_flush     <= '0;
                            r_stop      <= 1'b0;
                        end else begin
                            r_cnv <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign adc_cnv      = r_cnv;
    assign adc_sck      = r_sck;
    assign adc_din      = r_din;
    assign result_data  = r_result_data;
    assign result_ch    = r_result_ch;
    assign result_valid = r_result_valid;
    assign scan_done    = r_scan_done;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ad7689_conv_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ad7689_conv_sequencer
// Description : Bench for the AD7689 sequencer with a behavioural ADC model
//               and a frame-level scan model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad7689_conv_sequencer;

    localparam int         CLK_DIV = 2;
    localparam int         T_CONV  = 230;
    localparam int         T_GAP   = 4;
    localparam logic [2:0] REF_SEL = 3'b001;
    localparam int         FRAME   = T_CONV + 1 + 32 * CLK_DIV + T_GAP;

    logic        tb_ACLK    = 1'b0;
    logic        ARESET     = 1'b1;
    logic        enable     = 1'b0;
    logic        continuous = 1'b0;
    logic        start      = 1'b0;
    logic [7:0]  ch_mask    = 8'd0;
    logic        adc_sdo    = 1'b0;
    logic        adc_cnv, adc_sck, adc_din;
    logic [15:0] result_data;
    logic [2:0]  result_ch;
    logic        result_valid, scan_done, busy;

    always #5 tb_ACLK = ~tb_ACLK;

    ad7689_conv_sequencer #(
        .CLK_DIV(CLK_DIV), .T_CONV(T_CONV), .T_GAP(T_GAP), .REF_SEL(REF_SEL)
    ) dut (
        .ACLK(tb_ACLK), .ARESET(ARESET), .enable(enable), .continuous(continuous),
        .start(start), .ch_mask(ch_mask), .adc_cnv(adc_cnv), .adc_sck(adc_sck),
        .adc_din(adc_din), .adc_sdo(adc_sdo), .result_data(result_data),
        .result_ch(result_ch), .result_valid(result_valid), .scan_done(scan_done),
        .busy(busy)
    );

    typedef struct {
        logic [15:0] data;
        logic [2:0]  ch;
        logic        done;
        int          cyc;
        int          frame;
    } res_t;

    typedef struct {
        logic [7:0]  mask;
        int          frames;
        int          results;
        logic [15:0] first_din;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural ADC and pin monitor
    int          cyc = 0;
    bit          rand_data = 1'b0;
    int          rise_cyc_q[$];
    int          cnv_len_q[$];
    logic [15:0] din_q[$];
    logic [15:0] adc_word_q[$];
    res_t        res_q[$];
    int          sck_rises, sck_hi, din_glitch, sck_in_conv, done_cnt, done_bad;
    int          cnv_run, bit_idx, din_n, cur_frame;
    logic [15:0] cur_word = 16'd0;
    logic [15:0] din_sh = 16'd0;
    logic [15:0] tmp_w;
    logic [2:0]  prev_ch;
    logic        p_cnv = 1'b0, p_sck = 1'b0, p_din = 1'b0;

    always @(negedge tb_ACLK) begin
        cyc++;
        if (adc_cnv && !p_cnv) begin
            rise_cyc_q.push_back(cyc);
            cur_frame = rise_cyc_q.size() - 1;
            prev_ch = 3'd0;
            if (cur_frame >= 2 && din_q.size() > cur_frame - 2) begin
                tmp_w   = din_q[cur_frame - 2];
                prev_ch = tmp_w[11:9];
            end
            cur_word = (rand_data ? (16'($urandom) & 16'hFFF8) : 16'hA000) | {13'd0, prev_ch};
            adc_word_q.push_back(cur_word);
            bit_idx = 0;
            cnv_run = 0;
            din_n   = 0;
        end
        if (adc_cnv) cnv_run++;
        if (!adc_cnv && p_cnv) cnv_len_q.push_back(cnv_run);
        if (adc_sck && !p_sck) begin
            sck_rises++;
            din_sh = {din_sh[14:0], adc_din};
            din_n++;
            if (din_n == 16) din_q.push_back(din_sh);
            bit_idx++;
        end
        if (adc_sck) sck_hi++;
        if (adc_sck && adc_cnv) sck_in_conv++;
        if ((adc_din !== p_din) && !(p_sck && !adc_sck) && !(p_cnv && !adc_cnv)) din_glitch++;
        if (result_valid) res_q.push_back('{result_data, result_ch, scan_done, cyc, rise_cyc_q.size() - 1});
        if (scan_done) done_cnt++;
        if (scan_done && !result_valid) done_bad++;
        adc_sdo = (bit_idx < 16) ? cur_word[4'(15 - bit_idx)] : 1'b0;
        p_cnv = adc_cnv;
        p_sck = adc_sck;
        p_din = adc_din;
    end

    task automatic clear_monitor();
        rise_cyc_q.delete(); cnv_len_q.delete(); din_q.delete();
        adc_word_q.delete(); res_q.delete();
        sck_rises = 0; sck_hi = 0; din_glitch = 0; sck_in_conv = 0;
        done_cnt = 0; done_bad = 0; cnv_run = 0; bit_idx = 16; din_n = 0;
    endtask

    // One scan from start to IDLE, checked against a frame-level model of the scan
    task automatic run_scan(input logic [7:0] mask, input bit cont, input int stop_frame,
                            input bit rnd, input bit stray_start);
        logic [2:0]  set_ch[$];
        logic [2:0]  exp_ch[$];
        bit          exp_v[$];
        res_t        er[$];
        int          frames, drop_at, n;
        bit          dropped, timed_out;
        logic [15:0] exp_din;

        for (int c = 0; c < 8; c++) if (mask[c]) set_ch.push_back(3'(c));
        if (cont) begin
            frames = stop_frame + 1;
            for (int k = 0; k < frames; k++) begin
                exp_ch.push_back(set_ch[k % set_ch.size()]);
                exp_v.push_back(1'b1);
            end
        end else begin
            foreach (set_ch[i]) begin exp_ch.push_back(set_ch[i]); exp_v.push_back(1'b1); end
            for (int k = 0; k < 2; k++) begin exp_ch.push_back(set_ch[0]); exp_v.push_back(1'b0); end
            frames = exp_ch.size();
        end

        clear_monitor();
        rand_data = rnd;
        drop_at   = $urandom_range(5, T_CONV - 20);
        @(posedge tb_ACLK); #2;
        start = 1'b1; ch_mask = mask; continuous = cont; enable = 1'b1;
        @(posedge tb_ACLK); #2;
        start = 1'b0;
        if (!cont) ch_mask = 8'($urandom);
        dropped = 1'b0; timed_out = 1'b1;
        for (int t = 0; t < (frames + 2) * FRAME; t++) begin
            if (stray_start && t == 400) begin start = 1'b1; ch_mask = 8'hFF ^ mask; end
            if (stray_start && t == 401) start = 1'b0;
            if (cont && !dropped && rise_cyc_q.size() == stop_frame + 1 && cnv_run >= drop_at) begin
                enable = 1'b0; dropped = 1'b1;
            end
            if (!busy) begin timed_out = 1'b0; break; end
            @(posedge tb_ACLK); #2;
        end
        repeat (20) @(posedge tb_ACLK);
        #2;
        enable = 1'b1;

        for (int k = 2; k < frames; k++) begin
            if (exp_v[k - 2])
                er.push_back('{(k < adc_word_q.size()) ? adc_word_q[k] : 16'hxxxx,
                               exp_ch[k - 2], 1'b0, 0, k});
        end
        if (!cont && er.size() > 0) er[er.size() - 1].done = 1'b1;

        check("timeout", 32'(timed_out), 32'd0);
        check("frame_count", rise_cyc_q.size(), frames);
        n = (din_q.size() < frames) ? din_q.size() : frames;
        for (int k = 0; k < n; k++) begin
            exp_din = {1'b1, 3'b111, exp_ch[k], 1'b1, REF_SEL, 2'b00, 1'b1, 2'b00};
            check("din_word", din_q[k], exp_din);
        end
        foreach (cnv_len_q[i]) check("cnv_high_cycles", cnv_len_q[i], T_CONV);
        for (int k = 1; k < rise_cyc_q.size(); k++)
            check("frame_period", rise_cyc_q[k] - rise_cyc_q[k - 1], FRAME);
        check("sck_rises", sck_rises, 16 * frames);
        check("sck_high_cycles", sck_hi, 16 * CLK_DIV * frames);
        check("din_change_off_fall", din_glitch, 0);
        check("sck_during_cnv", sck_in_conv, 0);
        check("result_count", res_q.size(), er.size());
        n = (res_q.size() < er.size()) ? res_q.size() : er.size();
        for (int i = 0; i < n; i++) begin
            check("result_data", res_q[i].data, er[i].data);
            check("result_ch", 32'(res_q[i].ch), 32'(er[i].ch));
            check("scan_done_flag", 32'(res_q[i].done), 32'(er[i].done));
            check("result_frame", res_q[i].frame, er[i].frame);
            if (cont && i > 0) check("result_spacing", res_q[i].cyc - res_q[i - 1].cyc, FRAME);
        end
        check("scan_done_count", done_cnt, cont ? 0 : 1);
        check("scan_done_without_valid", done_bad, 0);
    endtask

    vec_t vecs[6];
    int   activity;
    bit   hit;

    initial begin
        vecs[0] = '{8'h05, 4, 2, 16'hF124};
        vecs[1] = '{8'h01, 3, 1, 16'hF124};
        vecs[2] = '{8'h80, 3, 1, 16'hFF24};
        vecs[3] = '{8'hFF, 10, 8, 16'hF124};
        vecs[4] = '{8'h06, 4, 2, 16'hF324};
        vecs[5] = '{8'h90, 4, 2, 16'hF924};

        clear_monitor();
        repeat (5) @(posedge tb_ACLK);
        #2;
        ARESET = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pins", {29'd0, adc_cnv, adc_sck, adc_din}, 32'd0);
        check("reset_result", {11'd0, result_data, result_ch, result_valid, scan_done}, 32'd0);

        // Table-driven single scans
        foreach (vecs[i]) begin
            run_scan(vecs[i].mask, 1'b0, 0, 1'b0, 1'b1);
            check("vec_frames", rise_cyc_q.size(), vecs[i].frames);
            check("vec_results", res_q.size(), vecs[i].results);
            check("vec_first_din", (din_q.size() > 0) ? din_q[0] : 16'hxxxx, vecs[i].first_din);
            if (i == 0 && res_q.size() == 2) begin
                check("m05_res0", {13'd0, res_q[0].ch, res_q[0].data}, {13'd0, 3'd0, 16'hA000});
                check("m05_res1", {12'd0, res_q[1].done, res_q[1].ch, res_q[1].data},
                      {12'd0, 1'b1, 3'd2, 16'hA002});
            end
        end

        // Zero mask and disabled start: no activity at all
        foreach (vecs[i]) begin end
        for (int s = 0; s < 2; s++) begin
            @(posedge tb_ACLK); #2;
            start = 1'b1; ch_mask = (s == 0) ? 8'h00 : 8'h0F; enable = (s != 0) ? 1'b0 : 1'b1;
            @(posedge tb_ACLK); #2;
            start = 1'b0;
            activity = 0;
            for (int t = 0; t < 1000; t++) begin
                if (busy || adc_cnv || adc_sck || adc_din) activity++;
                @(posedge tb_ACLK); #2;
            end
            check(s == 0 ? "zero_mask_activity" : "disabled_start_activity", activity, 0);
            enable = 1'b1;
        end

        // Continuous single-channel scan, enable dropped mid-CONV of the 6th frame
        run_scan(8'h80, 1'b1, 5, 1'b0, 1'b0);

        // Reset mid-XFER, then a fresh scan must not use stale tags
        clear_monitor();
        @(posedge tb_ACLK); #2;
        start = 1'b1; ch_mask = 8'h01; continuous = 1'b0; enable = 1'b1;
        @(posedge tb_ACLK); #2;
        start = 1'b0;
        hit = 1'b0;
        for (int t = 0; t < 2 * FRAME; t++) begin
            if (sck_rises == 7) begin hit = 1'b1; break; end
            @(posedge tb_ACLK); #2;
        end
        check("reach_bit7", 32'(hit), 32'd1);
        ARESET = 1'b1;
        @(posedge tb_ACLK); #2;
        ARESET = 1'b0;
        check("midxfer_reset_pins", {28'd0, adc_sck, adc_cnv, adc_din, busy}, 32'd0);
        check("midxfer_reset_result", {30'd0, result_valid, scan_done}, 32'd0);
        run_scan(8'h03, 1'b0, 0, 1'b1, 1'b0);

        // Randomized scans against the model
        for (int r = 0; r < 4; r++)
            run_scan(8'($urandom_range(1, 255)), 1'b0, 0, 1'b1, 1'b1);
        for (int r = 0; r < 2; r++)
            run_scan(8'($urandom_range(1, 255)), 1'b1, $urandom_range(2, 6), 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
